// File: rtl/risk_alarm_pkg.sv
// Shared level encoding, thresholds and the risk clamp for the landslide
// alert controller (optional peak tracker: RISK_ALARM_PEAK_EN).
package risk_alarm_pkg;

    typedef logic [1:0] level_t;

    localparam level_t LVL_LOW  = 2'd0;
    localparam level_t LVL_MED  = 2'd1;
    localparam level_t LVL_HIGH = 2'd2;

    localparam logic [7:0] RISK_MAX = 8'd100;

    localparam int DEF_MED_ON    = 40;
    localparam int DEF_MED_OFF   = 35;
    localparam int DEF_HIGH_ON   = 70;
    localparam int DEF_HIGH_OFF  = 65;
    localparam int DEF_PERSIST   = 3;
    localparam int DEF_BLINK_DIV = 1000000;

    function automatic logic [7:0] clamp_risk(input logic [7:0] r);
        return (r > RISK_MAX) ? RISK_MAX : r;
    endfunction

endpackage

// File: rtl/risk_blink_div.sv
// Enable-gated blink divider: square wave with BLINK_DIV-cycle half-period,
// held at 0 (divider cleared) whenever disabled or explicitly cleared.
module risk_blink_div #(
    parameter int BLINK_DIV = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic blink
);

    localparam int W = $clog2(BLINK_DIV);
    localparam logic [W-1:0] LAST = W'(BLINK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            blink <= 1'b0;
        end else if (!en || clr) begin
            cnt   <= '0;
            blink <= 1'b0;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            blink <= ~blink;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/risk_alarm_ctrl.sv
// Debounced, hysteretic LOW/MED/HIGH alert with latched HIGH alarm and blink.
// Define RISK_ALARM_PEAK_EN to build the peak-risk tracker.
module risk_alarm_ctrl
    import risk_alarm_pkg::*;
#(
    parameter int MED_ON    = DEF_MED_ON,
    parameter int MED_OFF   = DEF_MED_OFF,
    parameter int HIGH_ON   = DEF_HIGH_ON,
    parameter int HIGH_OFF  = DEF_HIGH_OFF,
    parameter int PERSIST   = DEF_PERSIST,
    parameter int BLINK_DIV = DEF_BLINK_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] risk_in,
    input  logic       risk_valid,
    input  logic       ack,
    output logic [1:0] alarm_level,
    output logic       alarm,
    output logic       blink,
    output logic [7:0] peak_risk
);

    localparam logic [7:0] MED_ON_C   = 8'(MED_ON);
    localparam logic [7:0] MED_OFF_C  = 8'(MED_OFF);
    localparam logic [7:0] HIGH_ON_C  = 8'(HIGH_ON);
    localparam logic [7:0] HIGH_OFF_C = 8'(HIGH_OFF);
    localparam logic [4:0] PERSIST_C  = 5'(PERSIST);

    level_t     level, level_nx;
    level_t     pend, pend_nx;
    level_t     cand;
    logic [3:0] cnt, cnt_nx;
    logic [4:0] cnt_inc;
    logic [7:0] r;
    logic       alarm_nx;
    logic       alarm_set;
    logic       alarm_clr;

    assign r = clamp_risk(risk_in);

    // Thresholds depend on where we are now, giving the hysteresis bands.
    always_comb begin
        cand = LVL_LOW;
        case (level)
            LVL_LOW: begin
                if (r >= HIGH_ON_C)     cand = LVL_HIGH;
                else if (r >= MED_ON_C) cand = LVL_MED;
                else                    cand = LVL_LOW;
            end
            LVL_MED: begin
                if (r >= HIGH_ON_C)     cand = LVL_HIGH;
                else if (r < MED_OFF_C) cand = LVL_LOW;
                else                    cand = LVL_MED;
            end
            default: begin
                if (r >= HIGH_OFF_C)     cand = LVL_HIGH;
                else if (r >= MED_OFF_C) cand = LVL_MED;
                else                     cand = LVL_LOW;
            end
        endcase
    end

    always_comb begin
        level_nx = level;
        pend_nx  = pend;
        cnt_nx   = cnt;
        cnt_inc  = 5'd0;
        if (risk_valid) begin
            if (cand == level) begin
                cnt_nx = 4'd0;
            end else begin
                if (cand != pend) begin
                    pend_nx = cand;
                    cnt_inc = 5'd1;
                end else begin
                    cnt_inc = {1'b0, cnt} + 5'd1;
                end
                if (cnt_inc == PERSIST_C) begin
                    level_nx = pend_nx;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx = cnt_inc[3:0];
                end
            end
        end
    end

    // Entering HIGH sets the alarm and beats a coincident ack.
    always_comb begin
        alarm_set = (level_nx == LVL_HIGH) && (level != LVL_HIGH);
        alarm_clr = alarm && ack && (level != LVL_HIGH);
        alarm_nx  = alarm_set || (alarm && !alarm_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= LVL_LOW;
            pend  <= LVL_LOW;
            cnt   <= 4'd0;
            alarm <= 1'b0;
        end else begin
            level <= level_nx;
            pend  <= pend_nx;
            cnt   <= cnt_nx;
            alarm <= alarm_nx;
        end
    end

    assign alarm_level = level;

    risk_blink_div #(
        .BLINK_DIV(BLINK_DIV)
    ) u_blink (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (alarm),
        .clr  (alarm && !alarm_nx),
        .blink(blink)
    );

`ifdef RISK_ALARM_PEAK_EN
    logic [7:0] peak;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak <= 8'd0;
        end else if (alarm && !alarm_nx) begin
            peak <= risk_valid ? r : 8'd0;
        end else if (risk_valid && (r > peak)) begin
            peak <= r;
        end
    end

    assign peak_risk = peak;
`else
    assign peak_risk = 8'd0;
`endif

endmodule
